// File: rtl/dmem_pkg.sv
// Shared types and constants for the M-stage data-memory bridge.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } dmem_state_e;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Store strobes must cover exactly the naturally aligned lanes for the size.
    function automatic logic sel_aligned(input logic [1:0] size, input logic [3:0] sel);
        case (size)
            SZ_WORD: sel_aligned = (sel == 4'b1111);
            SZ_HALF: sel_aligned = (sel == 4'b0011) || (sel == 4'b1100);
            default: sel_aligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_req_reg.sv
// Request-capture bank: holds addr/wdata/wr/size stable for the whole bus transfer.
module dmem_req_reg #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    output logic              o_wr,
    output logic [1:0]        o_size
);

    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic [1:0]        r_size;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_size  <= 2'd0;
        end else if (i_load) begin
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wr    <= i_wr;
            r_size  <= i_size;
        end
    end

    assign o_addr  = r_addr;
    assign o_wdata = r_wdata;
    assign o_wr    = r_wr;
    assign o_size  = r_size;

endmodule

// File: rtl/dmem_sramlike_bridge.sv
// M-stage load/store to sram-like (req/addr_ok/data_ok) bridge with pipeline stall and flush cancel.
// Optional stall-cycle counter enabled by defining DMEM_PERF_CNT_EN.
module dmem_sramlike_bridge
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic              cpu_wr,
    input  logic [3:0]        cpu_sel,
    input  logic [1:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_except,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    output logic [31:0]       stall_cycles
);

    dmem_state_e       r_state;
    dmem_state_e       w_next;
    logic              r_cancel;
    logic [DATA_W-1:0] r_rdata;
    logic              w_go;
    logic              w_cancel_path;
    logic              w_load;
    logic              w_busy;

    assign w_go          = cpu_en & ~cpu_except & ~flush;
    assign w_cancel_path = r_cancel | flush;
    assign w_load        = (r_state == IDLE) & w_go;
    assign w_busy        = (r_state == ADDR) | (r_state == DATA);

    dmem_req_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_addr  (cpu_addr),
        .i_wdata (cpu_wdata),
        .i_wr    (cpu_wr),
        .i_size  (cpu_size),
        .o_addr  (data_addr),
        .o_wdata (data_wdata),
        .o_wr    (data_wr),
        .o_size  (data_size)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_go) w_next = ADDR;
            ADDR:    if (data_addr_ok) w_next = DATA;
            // A cancelled transfer skips HOLD: the flushed instruction must not advance.
            DATA:    if (data_data_ok) w_next = w_cancel_path ? IDLE : HOLD;
            HOLD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cancel <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == DATA) && data_data_ok)
                r_cancel <= 1'b0;
            else if (w_busy && flush)
                r_cancel <= 1'b1;
            if ((r_state == DATA) && data_data_ok && !w_cancel_path && !data_wr)
                r_rdata <= data_rdata;
        end
    end

    assign data_req  = (r_state == ADDR);
    assign cpu_rdata = r_rdata;
    assign cpu_stall = cpu_en & ~cpu_except & (r_state != HOLD) & ~w_cancel_path;

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= 32'd0;
        else if (cpu_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cycles = r_stall_cnt;
`else
    assign stall_cycles = 32'd0;
`endif

    a_ok_overlap: assert property (@(posedge clk) disable iff (!rst)
        (r_state == ADDR) |-> !(data_addr_ok && data_data_ok));

    a_sel_align: assert property (@(posedge clk) disable iff (!rst)
        (w_go && cpu_wr) |-> sel_aligned(cpu_size, cpu_sel));

endmodule
